// File: rtl/daq2_bringup_seq_if.sv
// Converter-control and status bundle between the bring-up sequencer (slave)
// and the software/converter side (master).
interface daq2_bringup_seq_if;
    logic       start;
    logic       abort;
    logic [1:0] clkd_status;
    logic       tx_sync;
    logic       rx_sync;
    logic       dac_reset;
    logic       adc_pd;
    logic       dac_txen;
    logic       clkd_sync;
    logic       jesd_rst;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] state;
    logic [3:0] retry_cnt;

    modport master (
        output start, abort, clkd_status, tx_sync, rx_sync,
        input  dac_reset, adc_pd, dac_txen, clkd_sync, jesd_rst,
               busy, done, error, state, retry_cnt
    );

    modport slave (
        input  start, abort, clkd_status, tx_sync, rx_sync,
        output dac_reset, adc_pd, dac_txen, clkd_sync, jesd_rst,
               busy, done, error, state, retry_cnt
    );
endinterface

// File: rtl/daq2_bringup_seq.sv
// DAQ2 bring-up sequencer: clock lock, distributor SYNC, converter reset/release,
// JESD link release, link supervision with bounded retries.
module daq2_bringup_seq #(
    parameter int unsigned RESET_CYCLES      = 10000,
    parameter int unsigned SYNC_PULSE_CYCLES = 100,
    parameter int unsigned SETTLE_CYCLES     = 50000,
    parameter int unsigned LOCK_TIMEOUT      = 10000000,
    parameter int unsigned LINK_TIMEOUT      = 10000000,
    parameter int unsigned LINK_STABLE       = 16,
    parameter logic [3:0]  MAX_RETRY         = 4'd3
) (
    input  logic              clk,
    input  logic              reset,
    daq2_bringup_seq_if.slave bus
);
    localparam logic [3:0] ST_IDLE        = 4'd0;
    localparam logic [3:0] ST_CLK_WAIT    = 4'd1;
    localparam logic [3:0] ST_CLK_SYNC    = 4'd2;
    localparam logic [3:0] ST_DEV_RESET   = 4'd3;
    localparam logic [3:0] ST_DEV_RELEASE = 4'd4;
    localparam logic [3:0] ST_LINK_WAIT   = 4'd5;
    localparam logic [3:0] ST_RUN         = 4'd6;
    localparam logic [3:0] ST_ERROR       = 4'd7;

    // A zero-length parameter behaves as one cycle.
    localparam logic [31:0] L_RESET  = (RESET_CYCLES == 0)      ? 32'd1 : 32'(RESET_CYCLES);
    localparam logic [31:0] L_SYNC   = (SYNC_PULSE_CYCLES == 0) ? 32'd1 : 32'(SYNC_PULSE_CYCLES);
    localparam logic [31:0] L_SETTLE = (SETTLE_CYCLES == 0)     ? 32'd1 : 32'(SETTLE_CYCLES);
    localparam logic [31:0] L_LOCK   = (LOCK_TIMEOUT == 0)      ? 32'd1 : 32'(LOCK_TIMEOUT);
    localparam logic [31:0] L_LINK   = (LINK_TIMEOUT == 0)      ? 32'd1 : 32'(LINK_TIMEOUT);
    localparam logic [31:0] L_STABLE = (LINK_STABLE == 0)       ? 32'd1 : 32'(LINK_STABLE);

    logic [3:0]  r_state, w_state_next;
    logic [31:0] r_timer, w_timer_next;
    logic [31:0] r_stable, w_stable_next, w_stable_inc;
    logic [3:0]  r_retry, w_retry_next;
    logic        w_fault, w_lock, w_synced;
    logic        r_dac_reset, r_adc_pd, r_dac_txen, r_clkd_sync, r_jesd_rst;
    logic        r_busy, r_done, r_error;

    assign w_lock       = (bus.clkd_status == 2'b11);
    assign w_synced     = bus.tx_sync & bus.rx_sync;
    assign w_stable_inc = w_synced ? (r_stable + 32'd1) : 32'd0;

    always_comb begin
        w_state_next  = r_state;
        w_retry_next  = r_retry;
        w_stable_next = r_stable;
        w_timer_next  = (r_timer == 32'd0) ? 32'd0 : (r_timer - 32'd1);
        w_fault       = 1'b0;
        case (r_state)
            ST_IDLE, ST_ERROR: begin
                if (bus.start) begin
                    w_retry_next = 4'd0;
                    w_state_next = ST_CLK_WAIT;
                end
            end
            ST_CLK_WAIT: begin
                if (w_lock)                  w_state_next = ST_CLK_SYNC;
                else if (r_timer == 32'd0)   w_state_next = ST_ERROR;
            end
            ST_CLK_SYNC:    if (r_timer == 32'd0) w_state_next = ST_DEV_RESET;
            ST_DEV_RESET:   if (r_timer == 32'd0) w_state_next = ST_DEV_RELEASE;
            ST_DEV_RELEASE: if (r_timer == 32'd0) w_state_next = ST_LINK_WAIT;
            ST_LINK_WAIT: begin
                w_stable_next = w_stable_inc;
                if (w_stable_inc >= L_STABLE) w_state_next = ST_RUN;
                else if (r_timer == 32'd0)    w_fault      = 1'b1;
            end
            ST_RUN:  if (!w_lock || !w_synced) w_fault = 1'b1;
            default: w_state_next = ST_IDLE;
        endcase

        // Faults re-run the device/link portion only; clock setup is kept.
        if (w_fault) begin
            if (r_retry < MAX_RETRY) begin
                w_retry_next = r_retry + 4'd1;
                w_state_next = ST_DEV_RESET;
            end else begin
                w_state_next = ST_ERROR;
            end
        end

        if (bus.abort) begin
            w_state_next = ST_IDLE;
            w_retry_next = r_retry;
        end

        if (w_state_next != r_state) begin
            w_stable_next = 32'd0;
            case (w_state_next)
                ST_CLK_WAIT:    w_timer_next = L_LOCK - 32'd1;
                ST_CLK_SYNC:    w_timer_next = L_SYNC - 32'd1;
                ST_DEV_RESET:   w_timer_next = L_RESET - 32'd1;
                ST_DEV_RELEASE: w_timer_next = L_SETTLE - 32'd1;
                ST_LINK_WAIT:   w_timer_next = L_LINK - 32'd1;
                default:        w_timer_next = 32'd0;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change in the first cycle of it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_timer     <= 32'd0;
            r_stable    <= 32'd0;
            r_retry     <= 4'd0;
            r_dac_reset <= 1'b1;
            r_adc_pd    <= 1'b1;
            r_dac_txen  <= 1'b0;
            r_clkd_sync <= 1'b1;
            r_jesd_rst  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_timer     <= w_timer_next;
            r_stable    <= w_stable_next;
            r_retry     <= w_retry_next;
            r_dac_reset <= !(w_state_next inside {ST_DEV_RELEASE, ST_LINK_WAIT, ST_RUN});
            r_adc_pd    <= !(w_state_next inside {ST_DEV_RELEASE, ST_LINK_WAIT, ST_RUN});
            r_dac_txen  <= (w_state_next == ST_RUN);
            r_clkd_sync <= (w_state_next != ST_CLK_SYNC);
            r_jesd_rst  <= !(w_state_next inside {ST_LINK_WAIT, ST_RUN});
            r_busy      <= !(w_state_next inside {ST_IDLE, ST_RUN, ST_ERROR});
            r_done      <= (w_state_next == ST_RUN);
            r_error     <= (w_state_next == ST_ERROR);
        end
    end

    assign bus.state     = r_state;
    assign bus.retry_cnt = r_retry;
    assign bus.dac_reset = r_dac_reset;
    assign bus.adc_pd    = r_adc_pd;
    assign bus.dac_txen  = r_dac_txen;
    assign bus.clkd_sync = r_clkd_sync;
    assign bus.jesd_rst  = r_jesd_rst;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.error     = r_error;
endmodule

// File: tb/tb_daq2_bringup_seq.sv
// Bench for daq2_bringup_seq: directed bring-up scenarios plus randomized link
// glitches, checked each cycle against a phase/age reference model.
module tb_daq2_bringup_seq;
    localparam int P_RESET  = 8;
    localparam int P_SYNC   = 4;
    localparam int P_SETTLE = 6;
    localparam int P_LOCK   = 50;
    localparam int P_LINK   = 100;
    localparam int P_STABLE = 16;
    localparam int P_MAXR   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    daq2_bringup_seq_if bus();

    daq2_bringup_seq #(
        .RESET_CYCLES(P_RESET), .SYNC_PULSE_CYCLES(P_SYNC), .SETTLE_CYCLES(P_SETTLE),
        .LOCK_TIMEOUT(P_LOCK), .LINK_TIMEOUT(P_LINK), .LINK_STABLE(P_STABLE),
        .MAX_RETRY(4'(P_MAXR))
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int m_ph, m_age, m_hi, m_retry;
    int mode;
    int occ[8];
    int sync_low_seen, dev_entries, prev_state;

    // Expected {dac_reset, adc_pd, dac_txen, clkd_sync, jesd_rst, busy, done, error} per phase.
    function automatic logic [7:0] exp_outs(int ph);
        case (ph)
            0:       return 8'b1101_1000;
            1:       return 8'b1101_1100;
            2:       return 8'b1100_1100;
            3:       return 8'b1101_1100;
            4:       return 8'b0001_1100;
            5:       return 8'b0001_0100;
            6:       return 8'b0011_0010;
            7:       return 8'b1101_1001;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_state"}, 32'(bus.state), 32'(m_ph));
        chk({tag, "_retry_cnt"}, 32'(bus.retry_cnt), 32'(m_retry));
        chk({tag, "_outputs"}, 32'({bus.dac_reset, bus.adc_pd, bus.dac_txen, bus.clkd_sync,
                                    bus.jesd_rst, bus.busy, bus.done, bus.error}),
            32'(exp_outs(m_ph)));
    endtask

    task automatic model_reset();
        m_ph = 0; m_age = 0; m_hi = 0; m_retry = 0;
    endtask

    // Phase model: tracks cycles spent in the current phase and consecutive synced samples.
    task automatic model_step();
        int nxt;
        bit fault, lock, both;
        nxt   = m_ph;
        fault = 1'b0;
        lock  = (bus.clkd_status == 2'b11);
        both  = bus.tx_sync && bus.rx_sync;
        if (bus.abort) begin
            nxt = 0;
        end else begin
            case (m_ph)
                0, 7: if (bus.start) begin nxt = 1; m_retry = 0; end
                1: if (lock) nxt = 2; else if (m_age + 1 >= P_LOCK) nxt = 7;
                2: if (m_age + 1 >= P_SYNC) nxt = 3;
                3: if (m_age + 1 >= P_RESET) nxt = 4;
                4: if (m_age + 1 >= P_SETTLE) nxt = 5;
                5: begin
                    m_hi = both ? m_hi + 1 : 0;
                    if (m_hi >= P_STABLE) nxt = 6;
                    else if (m_age + 1 >= P_LINK) fault = 1'b1;
                end
                6: if (!(lock && both)) fault = 1'b1;
                default: nxt = 0;
            endcase
            if (fault) begin
                if (m_retry < P_MAXR) begin m_retry++; nxt = 3; end
                else nxt = 7;
            end
        end
        if (nxt != m_ph) begin m_age = 0; m_hi = 0; end
        else m_age++;
        m_ph = nxt;
    endtask

    task automatic tick();
        logic both;
        int sel;
        if (mode != 0) begin
            both = (m_ph == 5 || m_ph == 6);
            bus.tx_sync = both;
            bus.rx_sync = both;
            if (mode == 2 && m_ph == 5 && $urandom_range(0, 7) == 0) begin
                sel = int'($urandom_range(0, 2));
                if (sel != 1) bus.tx_sync = 1'b0;
                if (sel != 0) bus.rx_sync = 1'b0;
            end
        end
        @(posedge clk);
        model_step();
        #1;
        check_all("cycle");
        if (bus.state < 4'd8) occ[bus.state]++;
        if (bus.clkd_sync == 1'b0) sync_low_seen++;
        if (bus.state == 4'd3 && prev_state != 3) dev_entries++;
        prev_state = int'(bus.state);
    endtask

    task automatic run_until(input int t1, input int t2, input int budget, output int n);
        n = 0;
        while (m_ph != t1 && m_ph != t2 && n < budget) begin
            tick();
            n++;
        end
        chk("reach_state", 32'(bus.state == 4'(t1) || bus.state == 4'(t2)), 32'd1);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
    endtask

    task automatic do_abort();
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    endtask

    initial begin
        int n, k;
        reset = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.clkd_status = 2'b11;
        bus.tx_sync = 1'b0; bus.rx_sync = 1'b0;
        mode = 1; prev_state = 0; sync_low_seen = 0; dev_entries = 0;
        foreach (occ[i]) occ[i] = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // Nominal bring-up
        pulse_start();
        chk("start_to_clk_wait", 32'(bus.state), 32'd1);
        foreach (occ[i]) occ[i] = 0;
        sync_low_seen = 0;
        run_until(5, 5, 200, n);
        chk("clkd_sync_low_cycles", 32'(sync_low_seen), 32'(P_SYNC));
        chk("dev_reset_cycles", 32'(occ[3]), 32'(P_RESET));
        chk("dev_release_cycles", 32'(occ[4]), 32'(P_SETTLE));
        run_until(6, 6, 200, n);
        chk("link_wait_to_run", 32'(n), 32'(P_STABLE));
        repeat (5) tick();
        chk("nominal_txen", 32'(bus.dac_txen), 32'd1);

        // Sync glitch: first after 10 high cycles, then at random positions
        for (int r = 0; r < 3; r++) begin
            do_abort();
            mode = 0; bus.tx_sync = 1'b0; bus.rx_sync = 1'b0;
            pulse_start();
            run_until(5, 5, 200, n);
            bus.tx_sync = 1'b1; bus.rx_sync = 1'b1;
            k = (r == 0) ? 10 : int'($urandom_range(1, 14));
            repeat (k) tick();
            bus.rx_sync = 1'b0; tick(); bus.rx_sync = 1'b1;
            run_until(6, 6, 100, n);
            chk("glitch_to_run", 32'(n), 32'(P_STABLE));
        end

        // Retry exhaustion with tx_sync held low
        do_abort();
        bus.tx_sync = 1'b0; bus.rx_sync = 1'b1;
        dev_entries = 0;
        pulse_start();
        run_until(7, 7, 2000, n);
        chk("retry_dev_entries", 32'(dev_entries), 32'(P_MAXR + 1));
        chk("retry_exhausted_cnt", 32'(bus.retry_cnt), 32'(P_MAXR));

        // Lock timeout, started from ERROR
        bus.clkd_status = 2'b01;
        pulse_start();
        run_until(7, 7, 200, n);
        chk("lock_timeout_cycles", 32'(n), 32'(P_LOCK));
        chk("lock_timeout_error", 32'(bus.error), 32'd1);

        // Lock loss in RUN retries from DEV_RESET
        bus.clkd_status = 2'b11; mode = 1;
        pulse_start();
        run_until(6, 6, 300, n);
        repeat (3) tick();
        bus.clkd_status = 2'b10;
        tick();
        chk("run_fault_state", 32'(bus.state), 32'd3);
        chk("run_fault_txen", 32'(bus.dac_txen), 32'd0);
        chk("run_fault_retry", 32'(bus.retry_cnt), 32'd1);
        bus.clkd_status = 2'b11;
        run_until(6, 6, 300, n);
        chk("run_fault_recovered", 32'(bus.done), 32'd1);

        // Randomized link noise during LINK_WAIT
        mode = 2;
        for (int r = 0; r < 6; r++) begin
            do_abort();
            pulse_start();
            run_until(6, 7, 2000, n);
            repeat (3) tick();
        end

        // Abort beats start in IDLE
        mode = 0;
        do_abort();
        bus.abort = 1'b1; bus.start = 1'b1;
        repeat (2) tick();
        bus.abort = 1'b0; bus.start = 1'b0;
        chk("abort_start_idle", 32'(bus.state), 32'd0);

        // Abort in DEV_RELEASE
        pulse_start();
        run_until(4, 4, 200, n);
        do_abort();
        chk("abort_dev_release", 32'(bus.state), 32'd0);
        chk("abort_dev_release_dac_reset", 32'(bus.dac_reset), 32'd1);

        // Asynchronous reset in RUN
        mode = 1;
        pulse_start();
        run_until(6, 6, 300, n);
        repeat (2) tick();
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) tick();
        chk("after_reset_idle", 32'(bus.state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
